// File: rtl/rca_pipe_adder.sv
// Pipelined ripple-carry adder/subtractor; one beat/cycle, out_valid STAGES edges after accept, whole pipe freezes while output is stalled.
// Optional signed-overflow output when RCA_PIPE_OVF_EN is defined.
module rca_pipe_adder #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef RCA_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int SW = WIDTH / STAGES;

  // Rank 0 holds captured operands; rank k+1 holds the result of slice k.
  logic             vld_q [0:STAGES];
  logic             vld_d [0:STAGES];
  logic             c_q   [0:STAGES];
  logic             c_d   [0:STAGES];
  logic [WIDTH-1:0] a_q   [0:STAGES];
  logic [WIDTH-1:0] a_d   [0:STAGES];
  logic [WIDTH-1:0] b_q   [0:STAGES];
  logic [WIDTH-1:0] b_d   [0:STAGES];
  logic [WIDTH-1:0] s_q   [0:STAGES];
  logic [WIDTH-1:0] s_d   [0:STAGES];
  logic [SW:0]      slice [0:STAGES-1];
  logic             stall;

  assign stall    = vld_q[STAGES] & ~out_ready;
  assign in_ready = ~stall;

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      slice[k] = {1'b0, a_q[k][k*SW +: SW]} + {1'b0, b_q[k][k*SW +: SW]} + {{SW{1'b0}}, c_q[k]};
    end
    for (int k = 0; k <= STAGES; k++) begin
      vld_d[k] = vld_q[k];
      c_d[k]   = c_q[k];
      a_d[k]   = a_q[k];
      b_d[k]   = b_q[k];
      s_d[k]   = s_q[k];
    end
    if (!stall) begin
      vld_d[0] = in_valid;
      a_d[0]   = in1;
      b_d[0]   = sub ? ~in2 : in2;
      c_d[0]   = sub ? 1'b1 : cin;
      s_d[0]   = '0;
      for (int k = 0; k < STAGES; k++) begin
        vld_d[k+1]               = vld_q[k];
        c_d[k+1]                 = slice[k][SW];
        a_d[k+1]                 = a_q[k];
        b_d[k+1]                 = b_q[k];
        s_d[k+1]                 = s_q[k];
        s_d[k+1][k*SW +: SW]     = slice[k][SW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= STAGES; k++) begin
        vld_q[k] <= 1'b0;
        c_q[k]   <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k <= STAGES; k++) begin
        vld_q[k] <= vld_d[k];
        c_q[k]   <= c_d[k];
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        s_q[k]   <= s_d[k];
      end
    end
  end

  assign out_valid = vld_q[STAGES];
  assign sum       = s_q[STAGES];
  assign cout      = c_q[STAGES];

`ifdef RCA_PIPE_OVF_EN
  logic ovf_q;
  logic ovf_d;

  // Carry into the MSB is recovered as a^b^s at that bit, so no extra carry tap is needed.
  always_comb begin
    ovf_d = ovf_q;
    if (!stall) begin
      ovf_d = a_q[STAGES-1][WIDTH-1] ^ b_q[STAGES-1][WIDTH-1]
            ^ slice[STAGES-1][SW-1] ^ slice[STAGES-1][SW];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_rca_pipe_adder.sv
// Scoreboard bench for rca_pipe_adder (WIDTH=64, STAGES=4); checks ovf too when RCA_PIPE_OVF_EN is defined.
module tb_rca_pipe_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in1 = '0;
  logic [63:0] in2 = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] sum;
  logic        cout;
`ifdef RCA_PIPE_OVF_EN
  logic        ovf;
`endif

  int checks = 0;
  int errors = 0;
  int n_out = 0;
  int n_expect = 0;
  logic [65:0] sb [$];
  logic [65:0] mon_exp;
  logic [65:0] mon_act;

  always #5 clk = ~clk;

  rca_pipe_adder #(.WIDTH(64), .STAGES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in1      (in1),
    .in2      (in2),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout)
`ifdef RCA_PIPE_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // exp = {ovf, cout, sum}; pushed just before the accepting edge.
  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic ci, input logic s,
                      input logic [65:0] exp);
    int budget = 100;
    @(negedge clk);
    in1 = a; in2 = b; cin = ci; sub = s; in_valid = 1'b1;
    #1;
    while (!in_ready && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    if (budget == 0) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=in_ready_low expected=accept");
    end else begin
      sb.push_back(exp);
      n_expect++;
    end
    @(posedge clk);
  endtask

  task automatic drain();
    int budget = 200;
    while (sb.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d pending expected=0", sb.size());
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (!rst && out_valid && out_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%h expected=none", sum);
      end else begin
        mon_exp = sb.pop_front();
`ifdef RCA_PIPE_OVF_EN
        mon_act = {ovf, cout, sum};
`else
        mon_act = {1'b0, cout, sum};
        mon_exp[65] = 1'b0;
`endif
        chk("result", mon_act, mon_exp);
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int b;
    int n0;
    logic [63:0] s_hold;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 66'(out_valid), 66'd0);
    chk("rst_sum", 66'(sum), 66'd0);
    chk("rst_cout", 66'(cout), 66'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 66'(in_ready), 66'd1);

    // Single add and its latency
    send(64'd4036, 64'd2917, 1'b0, 1'b0, {2'b00, 64'd6953});
    #1 in_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid) break;
    end
    chk("latency", 66'(lat), 66'd4);
    drain();

    // Directed vectors back-to-back
    send(64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b1, 1'b0, {1'b0, 1'b0, 64'h1_FFFF_FFFF});
    send(64'd10000000000000000000, 64'd10000000000000000000, 1'b1, 1'b0,
         {1'b1, 1'b1, 64'd1553255926290448385});
    send(64'd5, 64'd7, 1'b1, 1'b1, {1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
    send(64'd5, 64'd7, 1'b0, 1'b1, {1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
    send(64'd7, 64'd5, 1'b0, 1'b1, {1'b0, 1'b1, 64'd2});
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, {1'b1, 1'b0, 64'h8000_0000_0000_0000});
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, {1'b0, 1'b1, 64'd0});
    send(64'd0, 64'd0, 1'b0, 1'b1, {1'b0, 1'b1, 64'd0});
    #1 in_valid = 1'b0;
    drain();

    // Backpressure: 3-cycle output stall mid-stream
    fork
      begin
        for (int k = 1; k <= 6; k++) begin
          send(64'(k), 64'(k), 1'b0, 1'b0, {2'b00, 64'(2 * k)});
        end
        #1 in_valid = 1'b0;
      end
      begin
        b = 0;
        while (!out_valid && b < 50) begin
          @(negedge clk);
          b++;
        end
        chk("bp_out_seen", 66'(out_valid), 66'd1);
        out_ready = 1'b0;
        s_hold = sum;
        for (int i = 0; i < 3; i++) begin
          #1;
          chk("bp_in_ready", 66'(in_ready), 66'd0);
          chk("bp_out_valid_held", 66'(out_valid), 66'd1);
          if (i > 0) chk("bp_sum_held", 66'(sum), 66'(s_hold));
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with beats in flight
    send(64'd100, 64'd1, 1'b0, 1'b0, {2'b00, 64'd101});
    send(64'd200, 64'd2, 1'b0, 1'b0, {2'b00, 64'd202});
    send(64'd300, 64'd3, 1'b0, 1'b0, {2'b00, 64'd303});
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("midrst_out_valid", 66'(out_valid), 66'd0);
    chk("midrst_sum", 66'(sum), 66'd0);
    chk("midrst_cout", 66'(cout), 66'd0);
    chk("midrst_inflight", 66'(sb.size()), 66'd3);
    n_expect -= sb.size();
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", 66'(in_ready), 66'd1);
    n0 = n_out;
    repeat (12) @(negedge clk);
    chk("midrst_no_stale", 66'(n_out - n0), 66'd0);

    chk("out_count", 66'(n_out), 66'(n_expect));
    chk("sb_empty", 66'(sb.size()), 66'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
